// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states, helpers.
package mul_div_unit_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_CALC   = 2'b01,
        S_FINISH = 2'b10
    } state_t;

    // Signed ops are the ones whose operand signs matter for the fix-up.
    function automatic logic isSignedOp(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/mdu_iter_step.sv
// One combinational iteration of the multiply/divide datapath.
// The accumulator holds {upper, lower} halves:
//   multiply: {partial product, remaining multiplier bits}
//   divide:   {partial remainder, dividend bits shifting into quotient}
module mdu_iter_step #(
    parameter int WIDTH = 32
) (
    input  logic                 isDiv,
    input  logic [2*WIDTH-1:0]   accIn,
    input  logic [WIDTH-1:0]     operand,
    output logic [2*WIDTH-1:0]   accOut
);

    logic [WIDTH:0] mulSum;
    logic [WIDTH:0] divShifted;
    logic [WIDTH:0] divDiff;
    logic           divFits;

    // Shift-add for multiply, restoring shift-subtract for divide
    always_comb begin
        // Add multiplicand when the current multiplier LSB is set; keep the carry.
        mulSum     = {1'b0, accIn[2*WIDTH-1:WIDTH]}
                   + {1'b0, (accIn[0] ? operand : {WIDTH{1'b0}})};
        // Bring the next dividend bit into the partial remainder.
        divShifted = {accIn[2*WIDTH-1:WIDTH], accIn[WIDTH-1]};
        divFits    = (divShifted >= {1'b0, operand});
        divDiff    = divShifted - {1'b0, operand};

        if (isDiv) begin
            accOut = divFits ? {divDiff[WIDTH-1:0], accIn[WIDTH-2:0], 1'b1}
                             : {divShifted[WIDTH-1:0], accIn[WIDTH-2:0], 1'b0};
        end else begin
            accOut = {mulSum, accIn[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Operands are converted to magnitudes at launch, iterated WIDTH times,
// then sign-corrected and written to HI/LO in the FINISH cycle.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             clrn,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    state_t             stateReg;
    state_t             stateNext;
    logic               isDivReg;
    logic               signA;
    logic               signB;
    logic               divZero;
    logic [WIDTH-1:0]   operand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] accStep;
    logic [CW-1:0]      count;

    logic               aNeg;
    logic               bNeg;
    logic [WIDTH-1:0]   aMag;
    logic [WIDTH-1:0]   bMag;
    logic               negResult;
    logic [2*WIDTH-1:0] prodFix;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   resHi;
    logic [WIDTH-1:0]   resLo;

    mdu_iter_step #(
        .WIDTH (WIDTH)
    ) uStep (
        .isDiv   (isDivReg),
        .accIn   (acc),
        .operand (operand),
        .accOut  (accStep)
    );

    // Operand magnitudes and signs at launch; unsigned ops see no sign
    always_comb begin
        aNeg = isSignedOp(op) & A[WIDTH-1];
        bNeg = isSignedOp(op) & B[WIDTH-1];
        aMag = aNeg ? -A : A;
        bMag = bNeg ? -B : B;
    end

    // Sign fix-up and divide-by-zero override applied at FINISH
    always_comb begin
        negResult = signA ^ signB;
        prodFix   = negResult ? -acc : acc;
        quot      = acc[WIDTH-1:0];
        rem       = acc[2*WIDTH-1:WIDTH];
        if (isDivReg) begin
            // Remainder equals |A| on divide-by-zero, so sign fix restores A exactly.
            resHi = signA ? -rem : rem;
            resLo = divZero ? {WIDTH{1'b1}} : (negResult ? -quot : quot);
        end else begin
            resHi = prodFix[2*WIDTH-1:WIDTH];
            resLo = prodFix[WIDTH-1:0];
        end
    end

    // FSM state register
    always_ff @(posedge CLK or posedge clrn) begin
        if (clrn) begin
            stateReg <= S_IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    // FSM next-state logic
    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            S_IDLE:   if (start) stateNext = S_CALC;
            S_CALC:   if (count == LAST_COUNT) stateNext = S_FINISH;
            S_FINISH: stateNext = S_IDLE;
            default:  stateNext = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (stateReg != S_IDLE);
    end

    // Datapath, HI/LO and done pulse
    always_ff @(posedge CLK or posedge clrn) begin
        if (clrn) begin
            HI       <= '0;
            LO       <= '0;
            done     <= 1'b0;
            isDivReg <= 1'b0;
            signA    <= 1'b0;
            signB    <= 1'b0;
            divZero  <= 1'b0;
            operand  <= '0;
            acc      <= '0;
            count    <= '0;
        end else begin
            done <= (stateReg == S_FINISH);
            case (stateReg)
                S_IDLE: begin
                    if (hi_we) HI <= wdata;
                    if (lo_we) LO <= wdata;
                    if (start) begin
                        isDivReg <= op[1];
                        signA    <= aNeg;
                        signB    <= bNeg;
                        divZero  <= (B == '0);
                        operand  <= op[1] ? bMag : aMag;
                        acc      <= op[1] ? {{WIDTH{1'b0}}, aMag} : {{WIDTH{1'b0}}, bMag};
                        count    <= '0;
                    end
                end
                S_CALC: begin
                    acc   <= accStep;
                    count <= count + CW'(1);
                end
                S_FINISH: begin
                    HI <= resHi;
                    LO <= resLo;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit.
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

    logic        CLK = 1'b0;
    logic        clrn;
    logic        start;
    logic [1:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        busy;
    logic        done;

    int assertCount = 0;
    int failCount   = 0;
    int cyc;
    int busyCyc;

    always #5 CLK = ~CLK;

    mul_div_unit #(
        .WIDTH (32)
    ) dut (
        .CLK   (CLK),
        .clrn  (clrn),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .HI    (HI),
        .LO    (LO),
        .busy  (busy),
        .done  (done)
    );

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
    endtask

    // Counts falling edges until done is seen (bounded); first edge is right after launch.
    task automatic waitDone();
        cyc     = 0;
        busyCyc = 0;
        do begin
            @(negedge CLK);
            cyc++;
            start = 1'b0;
            hi_we = 1'b0;
            lo_we = 1'b0;
            if (busy) busyCyc++;
        end while (!done && cyc < 100);
    endtask

    task automatic runOp(input string tag, input logic [1:0] o,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expHi, input logic [31:0] expLo);
        @(negedge CLK);
        launch(o, a, b);
        waitDone();
        checkEq({tag, "_lat"}, 32'(cyc), 32'd34);
        checkEq({tag, "_hi"}, HI, expHi);
        checkEq({tag, "_lo"}, LO, expLo);
    endtask

    initial begin
        clrn  = 1'b1;
        start = 1'b0;
        op    = OP_MULT;
        A     = '0;
        B     = '0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        wdata = '0;

        #1;
        checkEq("rst_hi", HI, 32'h0);
        checkEq("rst_lo", LO, 32'h0);
        checkEq("rst_busy", 32'(busy), 32'd0);
        checkEq("rst_done", 32'(done), 32'd0);
        repeat (2) @(negedge CLK);
        clrn = 1'b0;

        // Multiply
        runOp("mult_neg", OP_MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
        runOp("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);

        // Divide
        runOp("div_neg", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        runOp("divu", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
        runOp("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);

        // Async reset in the middle of a DIV
        @(negedge CLK);
        launch(OP_DIV, 32'd100, 32'd7);
        repeat (10) begin
            @(negedge CLK);
            start = 1'b0;
        end
        checkEq("pre_rst_busy", 32'(busy), 32'd1);
        clrn = 1'b1;
        #1;
        checkEq("midrst_hi", HI, 32'h0);
        checkEq("midrst_lo", LO, 32'h0);
        checkEq("midrst_busy", 32'(busy), 32'd0);
        checkEq("midrst_done", 32'(done), 32'd0);
        @(negedge CLK);
        clrn = 1'b0;
        runOp("post_rst", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);

        // Divide by zero
        runOp("divz", OP_DIVU, 32'd100, 32'd0, 32'h00000064, 32'hFFFFFFFF);
        checkEq("divz_busy_cycles", 32'(busyCyc), 32'd33);
        checkEq("divz_busy_at_done", 32'(busy), 32'd0);
        @(negedge CLK);
        checkEq("divz_done_once", 32'(done), 32'd0);
        runOp("divz_signed", OP_DIV, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF);

        // mthi in IDLE, mtlo while busy is ignored
        @(negedge CLK);
        hi_we = 1'b1;
        wdata = 32'h1234;
        @(negedge CLK);
        hi_we = 1'b0;
        checkEq("mthi_idle", HI, 32'h1234);
        launch(OP_DIVU, 32'd100, 32'd7);
        cyc = 0;
        do begin
            @(negedge CLK);
            cyc++;
            start = 1'b0;
            lo_we = (cyc == 3);
            wdata = 32'h55;
            if (cyc == 4) begin
                checkEq("mtlo_busy_lo", LO, 32'hFFFFFFFF);
                checkEq("calc_hold_hi", HI, 32'h1234);
            end
        end while (!done && cyc < 100);
        lo_we = 1'b0;
        checkEq("mtlo_busy_lat", 32'(cyc), 32'd34);
        checkEq("mtlo_busy_hi", HI, 32'd2);
        checkEq("mtlo_busy_lo_res", LO, 32'd14);

        // start while busy is ignored; start on the done cycle is accepted
        @(negedge CLK);
        launch(OP_DIVU, 32'd9, 32'd3);
        cyc = 0;
        do begin
            @(negedge CLK);
            cyc++;
            start = (cyc == 5);
            if (cyc == 5) begin
                op = OP_MULT;
                A  = 32'd2;
                B  = 32'd2;
            end
        end while (!done && cyc < 100);
        checkEq("busy_start_lat", 32'(cyc), 32'd34);
        checkEq("busy_start_hi", HI, 32'd0);
        checkEq("busy_start_lo", LO, 32'd3);
        launch(OP_MULT, 32'd2, 32'd2);
        waitDone();
        checkEq("b2b_lat", 32'(cyc), 32'd34);
        checkEq("b2b_hi", HI, 32'd0);
        checkEq("b2b_lo", LO, 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
